// File: rtl/spm_arbiter.sv
// Purpose: arbitrates SPM port B between the MEM stage (default owner) and a bus master (req/grant).
// Latency: port-B mux is combinational; grant and bus_rdy_ are registered (one edge).
// Backpressure: mem_busy stalls MEM while the bus owns the port; after MAX_WAIT contended cycles ownership is forced over.
//
// Ports:
//   clk, reset_                                  clock, async active-low reset
//   mem_addr/mem_as_/mem_rw/mem_wr_data          MEM-stage access in; mem_rd_data out, mem_busy stall out
//   bus_req_/bus_grnt_                           bus ownership handshake (active-low)
//   bus_addr/bus_as_/bus_rw/bus_wr_data          bus-side access in; bus_rd_data, bus_rdy_ out
//   spm_addr/spm_as_/spm_rw/spm_wr_data          SPM port-B drive; spm_rd_data valid one cycle after access
// rw encoding on every side: 1 = READ, 0 = WRITE. The SPM writes only when spm_as_=0 and spm_rw=0.
module spm_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic              clk,
    input  logic              reset_,
    // MEM stage
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_as_,
    input  logic              mem_rw,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_busy,
    // bus master
    input  logic              bus_req_,
    output logic              bus_grnt_,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_as_,
    input  logic              bus_rw,
    input  logic [DATA_W-1:0] bus_wr_data,
    output logic [DATA_W-1:0] bus_rd_data,
    output logic              bus_rdy_,
    // SPM port B
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
);

    typedef enum logic {
        OWN_MEM = 1'b0,
        OWN_BUS = 1'b1
    } own_t;

    own_t              state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              sel_bus;
    logic              contended;
    logic              expired;

    assign sel_bus = (state == OWN_BUS);

    // Both sides want the port this cycle; the same condition applies in either state.
    assign contended = !bus_req_ && !mem_as_;

    // The MAX_WAIT-th consecutive contended cycle hands the port to the waiting side.
    assign expired = contended && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    // Port B mux: no dead cycle on a switch, the new owner drives the SPM right after the edge.
    assign spm_addr    = sel_bus ? bus_addr    : mem_addr;
    assign spm_as_     = sel_bus ? bus_as_     : mem_as_;
    assign spm_rw      = sel_bus ? bus_rw      : mem_rw;
    assign spm_wr_data = sel_bus ? bus_wr_data : mem_wr_data;

    assign mem_rd_data = spm_rd_data;
    assign bus_rd_data = spm_rd_data;

    assign mem_busy = sel_bus && !mem_as_;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= OWN_MEM;
            wait_cnt  <= '0;
            bus_grnt_ <= 1'b1;
            bus_rdy_  <= 1'b1;
        end else begin
            // Only a bus access made while the bus owns the port reached the SPM.
            bus_rdy_ <= !(sel_bus && !bus_as_);

            case (state)
                OWN_MEM: begin
                    if ((!bus_req_ && mem_as_) || expired) begin
                        state     <= OWN_BUS;
                        bus_grnt_ <= 1'b0;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= contended ? wait_cnt + 1'b1 : '0;
                    end
                end
                OWN_BUS: begin
                    // Release wins together with expiry; both land in OWN_MEM anyway.
                    if (bus_req_ || expired) begin
                        state     <= OWN_MEM;
                        bus_grnt_ <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= contended ? wait_cnt + 1'b1 : '0;
                    end
                end
                default: begin
                    state     <= OWN_MEM;
                    bus_grnt_ <= 1'b1;
                    wait_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_arbiter.sv
module tb_spm_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;
    localparam int WAIT_W   = 4;
    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    logic              clk;
    logic              reset_;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_as_;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_busy;
    logic              bus_req_;
    logic              bus_grnt_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;
    logic [ADDR_W-1:0] spm_addr;
    logic              spm_as_;
    logic              spm_rw;
    logic [DATA_W-1:0] spm_wr_data;
    logic [DATA_W-1:0] spm_rd_data;

    int errors;
    int checks;

    spm_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)
    ) dut (
        .clk(clk), .reset_(reset_),
        .mem_addr(mem_addr), .mem_as_(mem_as_), .mem_rw(mem_rw), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_busy(mem_busy),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
        .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
        .spm_rd_data(spm_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratchpad model: synchronous write, read data registered one cycle after the strobe.
    logic [DATA_W-1:0] spm_mem [0:(1<<ADDR_W)-1];
    int strobe_cnt;
    always @(posedge clk) begin
        if (!spm_as_) begin
            if (spm_rw == WR) spm_mem[spm_addr] <= spm_wr_data;
            spm_rd_data <= spm_mem[spm_addr];
            strobe_cnt  <= strobe_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_as_     = 1'b1;
        mem_rw      = RD;
        mem_addr    = '0;
        mem_wr_data = '0;
        bus_req_    = 1'b1;
        bus_as_     = 1'b1;
        bus_rw      = RD;
        bus_addr    = '0;
        bus_wr_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_ = 1'b1;
        #3;
        reset_   = 1'b0;
        mem_as_  = 1'b0;
        mem_addr = 12'h0A5;
        #1;
        checks++; if (bus_grnt_ !== 1'b1) begin errors++; $display("FAIL reset_grnt got=%b exp=1", bus_grnt_); end
        checks++; if (bus_rdy_ !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", bus_rdy_); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", mem_busy); end
        checks++; if (spm_addr !== 12'h0A5 || spm_as_ !== 1'b0) begin errors++; $display("FAIL reset_mux got addr=%h as_=%b exp addr=0a5 as_=0", spm_addr, spm_as_); end
        idle_inputs();
        tick();
        tick();
        reset_ = 1'b1;
        tick();
    endtask

    task automatic test_idle_grant();
        bus_req_ = 1'b0;
        mem_as_  = 1'b1;
        tick();
        checks++; if (bus_grnt_ !== 1'b0) begin errors++; $display("FAIL grant_latency got=%b exp=0", bus_grnt_); end
        bus_as_ = 1'b0; bus_rw = WR; bus_addr = 12'h123; bus_wr_data = 32'hDEADBEEF;
        #1;
        checks++; if (spm_as_ !== 1'b0 || spm_addr !== 12'h123 || spm_rw !== WR) begin errors++; $display("FAIL grant_mux got as_=%b addr=%h rw=%b exp as_=0 addr=123 rw=0", spm_as_, spm_addr, spm_rw); end
        tick();
        checks++; if (bus_rdy_ !== 1'b0) begin errors++; $display("FAIL bus_wr_rdy got=%b exp=0", bus_rdy_); end
        bus_rw = RD;
        tick();
        checks++; if (bus_rdy_ !== 1'b0) begin errors++; $display("FAIL bus_rd_rdy got=%b exp=0", bus_rdy_); end
        checks++; if (bus_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bus_rd_data got=%h exp=deadbeef", bus_rd_data); end
        bus_as_ = 1'b1;
        tick();
        checks++; if (bus_rdy_ !== 1'b1) begin errors++; $display("FAIL bus_rdy_idle got=%b exp=1", bus_rdy_); end
        bus_req_ = 1'b1;
        tick();
        checks++; if (bus_grnt_ !== 1'b1) begin errors++; $display("FAIL release got=%b exp=1", bus_grnt_); end
    endtask

    task automatic test_reset_mid_grant();
        bus_req_ = 1'b0;
        tick();
        bus_as_ = 1'b0; bus_rw = WR; bus_addr = 12'h050; bus_wr_data = 32'h0BADF00D;
        tick();
        // Bus read in flight when reset strikes: it must not complete.
        bus_rw = RD;
        #2;
        reset_ = 1'b0;
        #1;
        checks++; if (bus_grnt_ !== 1'b1) begin errors++; $display("FAIL async_reset_grnt got=%b exp=1", bus_grnt_); end
        checks++; if (bus_rdy_ !== 1'b1) begin errors++; $display("FAIL async_reset_rdy got=%b exp=1", bus_rdy_); end
        tick();
        checks++; if (bus_rdy_ !== 1'b1) begin errors++; $display("FAIL reset_drop_rd got=%b exp=1", bus_rdy_); end
        idle_inputs();
        reset_ = 1'b1;
        mem_as_ = 1'b0; mem_rw = WR; mem_addr = 12'h010; mem_wr_data = 32'hCAFE0010;
        tick();
        checks++; if (bus_grnt_ !== 1'b1) begin errors++; $display("FAIL post_reset_own got=%b exp=1", bus_grnt_); end
        mem_rw = RD;
        tick();
        checks++; if (mem_rd_data !== 32'hCAFE0010) begin errors++; $display("FAIL mem_rd_010 got=%h exp=cafe0010", mem_rd_data); end
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        logic exp;
        mem_as_ = 1'b0; mem_rw = RD; mem_addr = 12'h040;
        bus_req_ = 1'b0;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            tick();
            exp = (i == MAX_WAIT) ? 1'b0 : 1'b1;
            checks++; if (bus_grnt_ !== exp) begin errors++; $display("FAIL starve_edge%0d got=%b exp=%b", i, bus_grnt_, exp); end
        end
        checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL starve_busy got=%b exp=1", mem_busy); end
        idle_inputs();
        tick();
        checks++; if (bus_grnt_ !== 1'b1) begin errors++; $display("FAIL starve_release got=%b exp=1", bus_grnt_); end
    endtask

    task automatic test_back_to_back_preempt();
        logic exp;
        int   cnt0;
        bus_req_ = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_as_ = 1'b0; bus_rw = WR; bus_addr = 12'h300 + 12'(i); bus_wr_data = 32'hB0000000 + 32'(i);
            tick();
            checks++; if (bus_rdy_ !== 1'b0) begin errors++; $display("FAIL b2b_rdy%0d got=%b exp=0", i, bus_rdy_); end
        end
        mem_as_ = 1'b0; mem_rw = RD; mem_addr = 12'h040;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            bus_addr = 12'h310 + 12'(i);
            #1;
            checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL preempt_busy%0d got=%b exp=1", i, mem_busy); end
            tick();
            exp = (i == MAX_WAIT) ? 1'b1 : 1'b0;
            checks++; if (bus_grnt_ !== exp) begin errors++; $display("FAIL preempt_edge%0d got=%b exp=%b", i, bus_grnt_, exp); end
            checks++; if (bus_rdy_ !== 1'b0) begin errors++; $display("FAIL preempt_rdy%0d got=%b exp=0", i, bus_rdy_); end
        end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL preempt_busy_drop got=%b exp=0", mem_busy); end
        // Bus access after revocation must be ignored.
        mem_as_ = 1'b1; bus_req_ = 1'b1;
        bus_as_ = 1'b0; bus_rw = WR; bus_addr = 12'h3FF; bus_wr_data = 32'h5A5A5A5A;
        #1;
        checks++; if (spm_as_ !== 1'b1) begin errors++; $display("FAIL ignored_strobe got=%b exp=1", spm_as_); end
        cnt0 = strobe_cnt;
        tick();
        checks++; if (bus_rdy_ !== 1'b1) begin errors++; $display("FAIL ignored_rdy got=%b exp=1", bus_rdy_); end
        checks++; if (strobe_cnt !== cnt0) begin errors++; $display("FAIL ignored_cnt got=%0d exp=%0d", strobe_cnt, cnt0); end
        idle_inputs();
        tick();
    endtask

    task automatic test_simultaneous();
        logic exp;
        bus_req_ = 1'b0;
        tick();
        checks++; if (bus_grnt_ !== 1'b0) begin errors++; $display("FAIL simul_grant got=%b exp=0", bus_grnt_); end
        mem_as_ = 1'b0; mem_rw = RD; mem_addr = 12'h040;
        for (int i = 1; i < MAX_WAIT; i++) tick();
        checks++; if (bus_grnt_ !== 1'b0) begin errors++; $display("FAIL simul_hold got=%b exp=0", bus_grnt_); end
        bus_req_ = 1'b1;
        tick();
        checks++; if (bus_grnt_ !== 1'b1) begin errors++; $display("FAIL simul_release got=%b exp=1", bus_grnt_); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL simul_busy got=%b exp=0", mem_busy); end
        bus_req_ = 1'b0; mem_as_ = 1'b1;
        tick();
        checks++; if (bus_grnt_ !== 1'b0) begin errors++; $display("FAIL simul_regrant got=%b exp=0", bus_grnt_); end
        // A full MAX_WAIT contended run is needed again: counter restarted from zero.
        mem_as_ = 1'b0;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            tick();
            exp = (i == MAX_WAIT) ? 1'b1 : 1'b0;
            checks++; if (bus_grnt_ !== exp) begin errors++; $display("FAIL simul_count%0d got=%b exp=%b", i, bus_grnt_, exp); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write_isolation();
        mem_as_ = 1'b0; mem_rw = WR; mem_addr = 12'h200; mem_wr_data = 32'h11111111;
        bus_req_ = 1'b0; bus_as_ = 1'b0; bus_rw = WR; bus_addr = 12'h200; bus_wr_data = 32'h22222222;
        #1;
        checks++; if (spm_wr_data !== 32'h11111111) begin errors++; $display("FAIL iso_wdata got=%h exp=11111111", spm_wr_data); end
        tick();
        checks++; if (bus_grnt_ !== 1'b1) begin errors++; $display("FAIL iso_grant got=%b exp=1", bus_grnt_); end
        checks++; if (bus_rdy_ !== 1'b1) begin errors++; $display("FAIL iso_rdy got=%b exp=1", bus_rdy_); end
        idle_inputs();
        mem_as_ = 1'b0; mem_rw = RD; mem_addr = 12'h200;
        tick();
        checks++; if (mem_rd_data !== 32'h11111111) begin errors++; $display("FAIL iso_rd got=%h exp=11111111", mem_rd_data); end
        idle_inputs();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_idle_grant();
        test_reset_mid_grant();
        test_starvation();
        test_back_to_back_preempt();
        test_simultaneous();
        test_write_isolation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
